uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that pairs with the UART receiver in the UART subsystem. It accepts a parallel word through a valid/busy handshake and shifts out a frame on `TX_OUT`: start bit, data LSB first, optional parity, one stop bit. Each bit is held for `prescale` clock cycles, so it runs on the same oversampling clock and prescale setting as the receiver. The TX-to-RX loopback uses both blocks unmodified.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits.
- `PRESCALE_WIDTH`, 6, width of the `prescale` input.

Ports:
- `CLK`  in  1  single clock for the block.
- `RST`  in  1  reset; synchronous, active-high.
- `P_DATA`  in  WIDTH  parallel word to transmit.
- `DATA_VALID`  in  1  request to transmit `P_DATA`.
- `PAR_EN`  in  1  1 = parity bit appended.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `prescale`  in  PRESCALE_WIDTH  clock cycles per bit.
- `TX_OUT`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `TX_OUT`=1, `busy`=0.
  - When `DATA_VALID`=1, the block latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `prescale` into internal registers, computes parity, clears the counters and moves to START.
- **START**
  - `TX_OUT`=0 for P cycles, then moves to DATA with bit index 0.
- **DATA**
  - `TX_OUT` = latched data[bit index], held for P cycles per bit.
  - After bit WIDTH-1, moves to PARITY if the latched `PAR_EN`=1, otherwise to STOP.
- **PARITY**
  - `TX_OUT` = XOR of all latched data bits, XORed with the latched `PAR_TYP`, held for P cycles.
  - Even parity: the count of ones in data plus parity is even. Odd parity: the count is odd.
- **STOP**
  - `TX_OUT`=1 for P cycles, then moves to IDLE.
- P (effective prescale):
  - P is the latched `prescale`; a latched value of 0 is treated as 1.
  - The cycle counter runs 0..P-1 and is PRESCALE_WIDTH bits wide.
  - The bit index counter is wide enough to hold WIDTH.
- Inputs are sampled only at acceptance. Changes to `P_DATA`, `PAR_EN`, `PAR_TYP` or `prescale` during a frame do not affect that frame.
- `DATA_VALID` while `busy`=1 is ignored; there is no queueing.
- `TX_OUT` and `busy` are registered outputs with no combinational path from inputs.

## Timing
- Reset values (applied at the clock edge where `RST`=1): state IDLE, `TX_OUT`=1, `busy`=0, all counters and latched registers 0.
- Acceptance:
  - `DATA_VALID`=1 with `busy`=0 in cycle n is accepted.
  - In cycle n+1, `TX_OUT`=0 (first start-bit cycle) and `busy`=1.
- Frame length: F = (2 + WIDTH + PAR_EN) × P cycles, covering cycles n+1 .. n+F.
- `busy`:
  - High for exactly cycles n+1 .. n+F.
  - Low in cycle n+F+1, with `TX_OUT`=1.
- Back-to-back:
  - If `DATA_VALID` is held high, the next frame is accepted in cycle n+F+1.
  - Its start bit appears in cycle n+F+2, so there is exactly one extra idle-high cycle between frames.
- Reset mid-frame:
  - The frame is aborted at the next edge: `TX_OUT`=1, `busy`=0.
  - The latched word is discarded and the block does not resume.
- `RST` and `DATA_VALID` asserted in the same cycle: reset wins and nothing is accepted.
- P=1: every state lasts one cycle; the frame is 10 cycles with no parity and 11 with parity (WIDTH=8).

## Test plan
- **Reset**: hold `RST`=1 for 3 cycles, then release. Required: `TX_OUT`=1, `busy`=0, and no activity while `DATA_VALID`=0.
- **Even parity frame**: `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, `prescale`=8. Required:
  - `TX_OUT` bit sequence 0,1,0,1,0,0,1,0,1,0,1 (start, data, parity 0, stop), each bit held 8 cycles.
  - `busy` high for exactly 88 cycles.
- **Odd parity / no parity**:
  - 0xA5 with `PAR_TYP`=1: parity bit must be 1.
  - 0x3C with `PAR_EN`=0, `prescale`=16: sequence 0,0,0,1,1,1,1,0,0,1, 160 cycles total.
- **Busy ignore and input stability**:
  - Mid-frame, pulse `DATA_VALID` with `P_DATA`=0xFF and change `prescale` to 4.
  - Required: the current frame is unchanged and no second frame follows.
- **Back-to-back and reset abort**:
  - Hold `DATA_VALID` high for words 0x55 then 0xAA. Required: exactly one idle cycle between the stop bit and the next start bit.
  - Assert `RST` during data bit 3. Required: `TX_OUT`=1 and `busy`=0 on the next edge.
- **Loopback**:
  - Drive `TX_OUT` into the UART receiver with matching `prescale`=8, `PAR_EN` and `PAR_TYP`, sending 0x00, 0xFF, 0x81, and 256 random words.
  - Required: the receiver's data-valid pulses once per word with matching data and no parity or stop errors.

Source files
------------

// File: rtl/uart_tx_if.sv
// UART transmitter request/status bundle: parallel word, frame options and line status.
// No storage; the master drives the request side, the slave drives TX_OUT and busy.
// Backpressure is signalled by busy; requests seen while busy are dropped, not queued.
interface uart_tx_if #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 6
);

  logic [WIDTH-1:0]          P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      TX_OUT;
  logic                      busy;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    output prescale,
    input  TX_OUT,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    input  prescale,
    output TX_OUT,
    output busy
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional parity, one stop bit.
// Latency: start bit on TX_OUT one cycle after an accepted DATA_VALID; each bit lasts max(prescale,1) cycles.
// Backpressure: busy is high for the whole frame; DATA_VALID while busy is ignored (no queueing).
module uart_tx #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic    CLK,
  input  logic    RST,
  uart_tx_if.slave bus
);

  // Bit index must be able to hold WIDTH itself.
  localparam int IDX_W = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]                state_q,   state_d;
  logic [WIDTH-1:0]          data_q,    data_d;
  logic                      par_en_q,  par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic [PRESCALE_WIDTH-1:0] presc_q,   presc_d;
  logic [PRESCALE_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic                      tx_out_q,  tx_out_d;
  logic                      busy_q,    busy_d;

  logic [PRESCALE_WIDTH-1:0] last_cnt;
  logic                      bit_done;
  logic [WIDTH-1:0]          data_shift;

  // Terminal count of the per-bit counter; a latched prescale of 0 behaves as 1.
  always_comb begin
    last_cnt = '0;
    if (presc_q != '0) begin
      last_cnt = presc_q - PRESCALE_WIDTH'(1);
    end
    bit_done = (cyc_cnt_q == last_cnt);
  end

  // Frame sequencing: next state, counters and the request latch.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    presc_d   = presc_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_idx_d = bit_idx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.DATA_VALID) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          // Even parity is the plain XOR; odd parity inverts it.
          par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
          presc_d   = bus.prescale;
          cyc_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (bit_done) begin
          cyc_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          cyc_cnt_d = cyc_cnt_q + PRESCALE_WIDTH'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cyc_cnt_d = '0;
          if (bit_idx_q == IDX_W'(WIDTH - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + PRESCALE_WIDTH'(1);
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          cyc_cnt_d = '0;
          state_d   = S_STOP;
        end else begin
          cyc_cnt_d = cyc_cnt_q + PRESCALE_WIDTH'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          cyc_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + PRESCALE_WIDTH'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line and busy are decoded from the next state so both leave a flop with no input-to-output path.
  always_comb begin
    data_shift = data_d >> bit_idx_d;
    tx_out_d   = 1'b1;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:   tx_out_d = 1'b1;
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = data_shift[0];
      S_PARITY: tx_out_d = par_bit_d;
      S_STOP:   tx_out_d = 1'b1;
      default:  tx_out_d = 1'b1;
    endcase
  end

  // State register; synchronous reset aborts any frame and clears the latched request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      presc_q   <= '0;
      cyc_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      presc_q   <= presc_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_out_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames, busy-ignore, back-to-back, reset abort, then random loopback.
// Expected frames go into queues at issue time; a cycle monitor and a serial receiver check independently.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx;

  localparam int W  = 8;
  localparam int PW = 6;

  typedef struct {
    int           n;       // acceptance cycle
    int           stop_c;  // last cycle the frame is on the line
    logic [W-1:0] d;
    bit           pe;
    bit           pt;
    int           p;       // effective cycles per bit
  } frame_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_tx_if #(.WIDTH(W), .PRESCALE_WIDTH(PW)) bus ();

  uart_tx #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  frame_t expq[$];
  frame_t rxq[$];
  int     total = 0;
  int     bad   = 0;
  bit     mon_en = 1'b0;
  bit     rx_en  = 1'b1;
  int     model_free = 0;

  function automatic int frame_len(frame_t f);
    return (2 + W + (f.pe ? 1 : 0)) * f.p;
  endfunction

  function automatic logic parity_of(logic [W-1:0] d, bit pt);
    // Parity bit makes the total count of ones even (pt=0) or odd (pt=1).
    return logic'(($countones(d) % 2) == 1) ^ pt;
  endfunction

  // Line level of bit slot k of a frame (0 = start).
  function automatic logic frame_bit(frame_t f, int k);
    if (k == 0) return 1'b0;
    if (k <= W) return f.d[k-1];
    if (f.pe && k == W + 1) return parity_of(f.d, f.pt);
    return 1'b1;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endfunction

  // Cycle-exact monitor: expected {busy,TX_OUT} from the frame currently owning the line.
  logic [1:0] mon_e;
  always @(negedge CLK) begin
    if (mon_en) begin
      while (expq.size() > 0 && expq[0].stop_c < cyc) void'(expq.pop_front());
      mon_e = 2'b01;
      if (expq.size() > 0 && expq[0].n < cyc)
        mon_e = {1'b1, frame_bit(expq[0], (cyc - expq[0].n - 1) / expq[0].p)};
      chk("line", 32'({bus.busy, bus.TX_OUT}), 32'(mon_e));
    end
  end

  // Loopback receiver: mid-bit sampling of TX_OUT with the frame's own settings.
  task automatic rx_frame();
    frame_t       f;
    logic [W-1:0] d;
    logic         st, par, sp;
    if (rxq.size() == 0) begin
      chk("rx_unexpected_frame", 32'd1, 32'd0);
      return;
    end
    f = rxq.pop_front();
    d = '0;
    par = 1'b0;
    repeat (f.p / 2) @(negedge CLK);
    st = bus.TX_OUT;
    for (int k = 0; k < W; k++) begin
      repeat (f.p) @(negedge CLK);
      d[k] = bus.TX_OUT;
    end
    if (f.pe) begin
      repeat (f.p) @(negedge CLK);
      par = bus.TX_OUT;
    end
    repeat (f.p) @(negedge CLK);
    sp = bus.TX_OUT;
    chk("rx_start", 32'(st), 32'd0);
    chk("rx_data", 32'(d), 32'(f.d));
    if (f.pe) chk("rx_parity", 32'(par), 32'(parity_of(f.d, f.pt)));
    chk("rx_stop", 32'(sp), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en && rx_en && bus.TX_OUT === 1'b0) rx_frame();
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request as soon as the model says the transmitter is free.
  task automatic send(logic [W-1:0] d, bit pe, bit pt, logic [PW-1:0] ps, bit hold);
    frame_t f;
    while (cyc < model_free) tick();
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.prescale   = ps;
    bus.DATA_VALID = 1'b1;
    f.n      = cyc;
    f.d      = d;
    f.pe     = pe;
    f.pt     = pt;
    f.p      = (ps == 0) ? 1 : int'(ps);
    f.stop_c = cyc + frame_len(f);
    model_free = f.stop_c + 1;
    expq.push_back(f);
    if (rx_en) rxq.push_back(f);
    tick();
    if (!hold) bus.DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    while (cyc <= model_free) tick();
    b = 0;
    while (rxq.size() > 0 && b < 300) begin
      tick();
      b++;
    end
  endtask

  task automatic do_reset(int ncyc);
    RST = 1'b1;
    if (expq.size() > 0 && expq[0].stop_c > cyc) expq[0].stop_c = cyc;
    repeat (ncyc) tick();
    RST = 1'b0;
    model_free = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold;
    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.prescale   = '0;
    RST            = 1'b1;

    // Reset for 3 cycles; monitor starts once the first reset edge has been taken.
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    model_free = cyc;
    repeat (10) tick();

    // Directed frames: even parity, odd parity, no parity at prescale 16.
    send(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0);
    wait_idle();
    send(8'hA5, 1'b1, 1'b1, 6'd8, 1'b0);
    wait_idle();
    send(8'h3C, 1'b0, 1'b0, 6'd16, 1'b0);
    wait_idle();

    // Mid-frame request with different word and prescale must be ignored.
    send(8'h96, 1'b1, 1'b0, 6'd8, 1'b0);
    repeat (20) tick();
    bus.P_DATA     = 8'hFF;
    bus.prescale   = 6'd4;
    bus.DATA_VALID = 1'b1;
    tick();
    bus.DATA_VALID = 1'b0;
    wait_idle();
    repeat (20) tick();

    // Back-to-back with DATA_VALID held high.
    send(8'h55, 1'b0, 1'b0, 6'd8, 1'b1);
    send(8'hAA, 1'b1, 1'b1, 6'd8, 1'b0);
    wait_idle();

    // Reset during data bit 3 aborts the frame; receiver is parked for the partial frame.
    rx_en = 1'b0;
    send(8'hC3, 1'b1, 1'b0, 6'd8, 1'b0);
    repeat (4 * 8 + 3) tick();
    do_reset(1);
    repeat (10) tick();

    // Reset and request in the same cycle: nothing is accepted.
    bus.P_DATA     = 8'h5A;
    bus.DATA_VALID = 1'b1;
    RST            = 1'b1;
    tick();
    RST            = 1'b0;
    bus.DATA_VALID = 1'b0;
    model_free     = cyc;
    repeat (10) tick();
    rx_en = 1'b1;

    // Loopback: corner words then random traffic at prescale 8.
    send(8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'd8, 1'b0);
    send(8'hFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'd8, 1'b0);
    send(8'h81, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'd8, 1'b0);
    for (int i = 0; i < 256; i++) begin
      hold = (i < 255) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'd8, hold);
      if (!hold) repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();

    // Small prescales, including 0 which behaves as 1.
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 5)), 1'b0);
    end
    wait_idle();
    repeat (10) tick();

    chk("rx_drain", 32'(rxq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
